// File: rtl/ov7670_config_sequencer_if.sv
// Write-request channel between the OV7670 config sequencer and the SCCB master.
// master = sequencer side (issues writes), slave = SCCB engine side.
interface ov7670_config_sequencer_if;
   logic       sccb_start;
   logic [7:0] sccb_reg;
   logic [7:0] sccb_val;
   logic       sccb_ready;
   logic       sccb_nack;

   modport master (
      output sccb_start,
      output sccb_reg,
      output sccb_val,
      input  sccb_ready,
      input  sccb_nack
   );

   modport slave (
      input  sccb_start,
      input  sccb_reg,
      input  sccb_val,
      output sccb_ready,
      output sccb_nack
   );
endinterface

// File: rtl/ov7670_config_sequencer.sv
// Walks the OV7670 config ROM and issues one SCCB register write per entry.
// 16'hFFF0 entries insert a fixed delay, 16'hFFFF ends the sequence.
module ov7670_config_sequencer #(
   parameter int unsigned CLK_HZ   = 24000000,
   parameter int unsigned DELAY_MS = 10
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               start,
   output logic [7:0]                         rom_addr,
   input  logic [15:0]                        rom_data,
   ov7670_config_sequencer_if.master          sccb,
   output logic                               busy,
   output logic                               done,
   output logic                               err
);
   localparam logic [31:0] DELAY_CYCLES = 32'((CLK_HZ / 1000) * DELAY_MS);
   localparam logic [15:0] MARK_END     = 16'hFFFF;
   localparam logic [15:0] MARK_DELAY   = 16'hFFF0;

   typedef enum logic [2:0] {
      IDLE, FETCH, DECODE, WAIT_BUSY, WAIT_DONE, DELAY, DONE
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  rom_addr_q, rom_addr_d;
   logic        sccb_start_q, sccb_start_d;
   logic [7:0]  sccb_reg_q, sccb_reg_d;
   logic [7:0]  sccb_val_q, sccb_val_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [31:0] cnt_q, cnt_d;
   logic        advance;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         rom_addr_q   <= '0;
         sccb_start_q <= 1'b0;
         sccb_reg_q   <= '0;
         sccb_val_q   <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         rom_addr_q   <= rom_addr_d;
         sccb_start_q <= sccb_start_d;
         sccb_reg_q   <= sccb_reg_d;
         sccb_val_q   <= sccb_val_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
         cnt_q        <= cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      rom_addr_d   = rom_addr_q;
      sccb_start_d = 1'b0;
      sccb_reg_d   = sccb_reg_q;
      sccb_val_d   = sccb_val_q;
      done_d       = done_q;
      err_d        = err_q;
      cnt_d        = cnt_q;
      advance      = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               rom_addr_d = '0;
               done_d     = 1'b0;
               err_d      = 1'b0;
               state_d    = FETCH;
            end
         end
         FETCH: state_d = DECODE;
         DECODE: begin
            if (rom_data == MARK_END) begin
               done_d  = 1'b1;
               state_d = DONE;
            end else if (rom_data == MARK_DELAY) begin
               cnt_d   = DELAY_CYCLES - 32'd1;
               state_d = DELAY;
            end else if (sccb.sccb_ready) begin
               sccb_reg_d   = rom_data[15:8];
               sccb_val_d   = rom_data[7:0];
               sccb_start_d = 1'b1;
               state_d      = WAIT_BUSY;
            end
         end
         WAIT_BUSY: begin
            if (!sccb.sccb_ready) state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            // A NACK is recorded but the rest of the table is still written.
            if (sccb.sccb_ready) begin
               err_d   = err_q | sccb.sccb_nack;
               advance = 1'b1;
            end
         end
         DELAY: begin
            if (cnt_q == 32'd0) advance = 1'b1;
            else                cnt_d   = cnt_q - 32'd1;
         end
         default: state_d = IDLE;
      endcase

      if (advance) begin
         if (rom_addr_q != 8'hFF) begin
            rom_addr_d = rom_addr_q + 8'd1;
            state_d    = FETCH;
         end else begin
            done_d  = 1'b1;
            state_d = DONE;
         end
      end

      busy_d = !((state_d == IDLE) || (state_d == DONE));
   end

   assign rom_addr        = rom_addr_q;
   assign sccb.sccb_start = sccb_start_q;
   assign sccb.sccb_reg   = sccb_reg_q;
   assign sccb.sccb_val   = sccb_val_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign err             = err_q;
endmodule
